// File: rtl/br_pkg.sv
// Shared PS/2 receiver state encoding, scan-code constants and direction bit map.
package br_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  localparam int unsigned DIR_UP    = 0;
  localparam int unsigned DIR_DOWN  = 1;
  localparam int unsigned DIR_LEFT  = 2;
  localparam int unsigned DIR_RIGHT = 3;

  // One-hot direction mask for an extended arrow code, zero for anything else.
  function automatic logic [3:0] arrow_mask(input logic [7:0] code);
    logic [3:0] m;
    m = '0;
    case (code)
      SC_UP:    m[DIR_UP]    = 1'b1;
      SC_DOWN:  m[DIR_DOWN]  = 1'b1;
      SC_LEFT:  m[DIR_LEFT]  = 1'b1;
      SC_RIGHT: m[DIR_RIGHT] = 1'b1;
      default:  m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: input synchronisers, clock glitch filter, framing FSM with timeout.
module ps2_rx
  import br_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 131072
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [7:0] data,
  output logic       good,
  output logic       err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]            ps2c_sync_q, ps2c_sync_d;
  logic [1:0]            ps2d_sync_q, ps2d_sync_d;
  logic [FILTER_LEN-1:0] filter_q, filter_d;
  logic                  fclk_q, fclk_d;
  logic                  fall;
  logic                  bit_in;
  rx_state_e             state_q, state_d;
  logic [7:0]            shift_q, shift_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  par_q, par_d;
  logic [TW-1:0]         timer_q, timer_d;

  always_comb begin
    ps2c_sync_d = {ps2c_sync_q[0], ps2c};
    ps2d_sync_d = {ps2d_sync_q[0], ps2d};
    filter_d    = {filter_q[FILTER_LEN-2:0], ps2c_sync_q[1]};
    fclk_d      = fclk_q;
    if (filter_q == '0)
      fclk_d = 1'b0;
    else if (filter_q == '1)
      fclk_d = 1'b1;
  end

  assign fall   = fclk_q & ~fclk_d;
  assign bit_in = ps2d_sync_q[1];
  assign data   = shift_q;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    timer_d = fall ? '0 : timer_q + TW'(1);
    good    = 1'b0;
    err     = 1'b0;
    case (state_q)
      RX_IDLE: begin
        timer_d = '0;
        if (fall && !bit_in) begin
          state_d = RX_DATA;
          cnt_d   = '0;
        end
      end
      RX_DATA: if (fall) begin
        shift_d = {bit_in, shift_q[7:1]};
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7)
          state_d = RX_PARITY;
      end
      RX_PARITY: if (fall) begin
        par_d   = bit_in;
        state_d = RX_STOP;
      end
      RX_STOP: if (fall) begin
        state_d = RX_IDLE;
        if ((^{shift_q, par_q}) && bit_in)
          good = 1'b1;
        else
          err = 1'b1;
      end
      default: state_d = RX_IDLE;
    endcase
    // A stalled frame is abandoned only when no edge arrives on the terminal count.
    if (state_q != RX_IDLE && !fall && timer_q == TMAX) begin
      state_d = RX_IDLE;
      timer_d = '0;
      err     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      ps2c_sync_q <= '1;
      ps2d_sync_q <= '1;
      filter_q    <= '1;
      fclk_q      <= 1'b1;
      state_q     <= RX_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      par_q       <= 1'b0;
      timer_q     <= '0;
    end else begin
      ps2c_sync_q <= ps2c_sync_d;
      ps2d_sync_q <= ps2d_sync_d;
      filter_q    <= filter_d;
      fclk_q      <= fclk_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      par_q       <= par_d;
      timer_q     <= timer_d;
    end
  end

endmodule

// File: rtl/ps2_direction_decoder.sv
// PS/2 keyboard front end: arrow keys to held direction bits, Enter to a start pulse.
module ps2_direction_decoder
  import br_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 131072
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [3:0] direction,
  output logic       start_key,
  output logic [7:0] key_code,
  output logic       byte_valid,
  output logic       frame_err
);

  logic [7:0] rx_data;
  logic       rx_good;
  logic       rx_err;
  logic [3:0] mask;

  logic [3:0] direction_q, direction_d;
  logic       start_key_q, start_key_d;
  logic [7:0] key_code_q, key_code_d;
  logic       byte_valid_q, byte_valid_d;
  logic       frame_err_q, frame_err_d;
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;

  ps2_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk  (clk),
    .clr  (clr),
    .ps2c (ps2c),
    .ps2d (ps2d),
    .data (rx_data),
    .good (rx_good),
    .err  (rx_err)
  );

  assign mask = arrow_mask(rx_data);

  always_comb begin
    direction_d  = direction_q;
    start_key_d  = 1'b0;
    key_code_d   = key_code_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    ext_d        = ext_q;
    brk_d        = brk_q;
    if (rx_err) begin
      frame_err_d = 1'b1;
      ext_d       = 1'b0;
      brk_d       = 1'b0;
    end else if (rx_good) begin
      key_code_d   = rx_data;
      byte_valid_d = 1'b1;
      if (rx_data == SC_EXT) begin
        ext_d = 1'b1;
      end else if (rx_data == SC_BRK) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (ext_q)
          direction_d = brk_q ? (direction_q & ~mask) : (direction_q | mask);
        if (!ext_q && !brk_q && rx_data == SC_ENTER)
          start_key_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      direction_q  <= '0;
      start_key_q  <= 1'b0;
      key_code_q   <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
    end else begin
      direction_q  <= direction_d;
      start_key_q  <= start_key_d;
      key_code_q   <= key_code_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
    end
  end

  assign direction  = direction_q;
  assign start_key  = start_key_q;
  assign key_code   = key_code_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: doc/ps2_direction_decoder.md
PS2_DIRECTION_DECODER -- requirements
Module: ps2_direction_decoder

Interface
REQ-001 SHALL have parameter FILTER_LEN, 8, ps2c glitch-filter depth in clk cycles.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, 131072, maximum clk cycles between falling ps2c edges inside a frame.
REQ-003 SHALL have port clk  input  1  system clock (100 MHz); the block's only clock.
REQ-004 SHALL have port clr  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port ps2c  input  1  raw keyboard clock, asynchronous.
REQ-006 SHALL have port ps2d  input  1  raw keyboard data, asynchronous.
REQ-007 SHALL have port direction  output  4  held keys; bit 0 up (E0 75), 1 down (E0 72), 2 left (E0 6B), 3 right (E0 74).
REQ-008 SHALL have port start_key  output  1  one-cycle pulse on the Enter make code (5A, no E0 prefix).
REQ-009 SHALL have port key_code  output  8  last byte received with good parity.
REQ-010 SHALL have port byte_valid  output  1  one-cycle pulse when key_code updates.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse on a parity, stop-bit or timeout error.

Function
REQ-012 SHALL synchronise ps2c and ps2d through two flops each before any other use.
REQ-013 SHALL shift synchronised ps2c into a FILTER_LEN-bit register; the filtered clock goes to 0 when the register is all zeros and to 1 when it is all ones, and otherwise holds.
REQ-014 SHALL sample synchronised ps2d on the cycle the filtered clock falls (fall event).
REQ-015 SHALL implement FSM IDLE->DATA->PARITY->STOP->IDLE, advancing only on fall events.
REQ-016 SHALL, in IDLE, move to DATA only when the sampled bit is 0 (start bit); a sampled 1 is ignored.
REQ-017 SHALL, in DATA, shift 8 bits LSB-first using a 3-bit counter, and move to PARITY after the 8th bit.
REQ-018 SHALL treat a byte as good when the parity bit gives odd parity over data+parity and the stop bit is 1.
REQ-019 SHALL, on a good byte, update key_code and pulse byte_valid exactly one clk cycle after the stop-bit fall event.
REQ-020 SHALL, on a bad parity or stop bit, leave key_code unchanged, pulse frame_err at the same cycle position as byte_valid, and clear the prefix flags.
REQ-021 SHALL count cycles since the last fall event while outside IDLE; on reaching TIMEOUT_CYCLES-1 it SHALL return to IDLE, pulse frame_err and clear the prefix flags.
REQ-022 SHALL run the decoder on a good byte: E0 sets ext; F0 sets brk; any other byte is a key code, after which ext and brk clear.
REQ-023 SHALL, for a key code with ext=1 that matches an arrow, set that direction bit on make (brk=0) and clear it on break (brk=1), in the same cycle as byte_valid.
REQ-024 SHALL pulse start_key with byte_valid for code 5A with ext=0 and brk=0; key-repeat makes pulse again.
REQ-025 SHALL ignore unmapped codes, leave direction unchanged, and still update key_code.
REQ-026 SHALL keep the other bits of direction unchanged when one arrow changes; opposing arrows may both be 1.

Reset
REQ-027 SHALL, on clr, within one cycle: set FSM to IDLE, and clear counters, shift registers, ext and brk; set direction=0, key_code=00, byte_valid=0, start_key=0, frame_err=0; set filter register and filtered clock to all-ones / 1.
REQ-028 SHALL discard any frame in progress when clr is asserted, with no pulse on any output.

Structure
REQ-029 SHALL place the FSM state enum, the scan-code constants (E0, F0, 75, 72, 6B, 74, 5A) and the direction bit indices in the shared package br_pkg.
REQ-030 SHALL split the frame receiver into sub-module ps2_rx (FSM items REQ-012 to REQ-021, outputs data and pulses); the decoder stays in the top module.

Verification
REQ-031 SHALL have a bench case: frame E0, then 75, each with valid odd parity -> direction=0001 one cycle after the second stop bit; byte_valid pulsed twice.
REQ-032 SHALL have a bench case: E0 F0 75 after case REQ-031 -> direction=0000; key_code=75.
REQ-033 SHALL have a bench case: byte 5A with the parity bit inverted -> frame_err pulses once; key_code, direction and start_key unchanged.
REQ-034 SHALL have a bench case: 1-cycle ps2c glitch low while IDLE -> no FSM transition and no output activity.
REQ-035 SHALL have a bench case: start bit plus 4 data bits, then ps2c idle for TIMEOUT_CYCLES -> frame_err pulse, FSM IDLE; a following byte 5A decodes with a start_key pulse.
REQ-036 SHALL have a bench case: clr asserted mid-frame while direction=1000 -> next cycle direction=0000 and FSM IDLE, with no frame_err.
